// File: rtl/skolem_sweep_if.sv
// rtl/skolem_sweep_if.sv - sweep control, vector and response signals of the Skolem sweep checker
interface skolem_sweep_if #(
  parameter int NIN = 8
);
  logic           start_i;
  logic [NIN-1:0] vec_o;
  logic           vec_vld_o;
  logic           skolem_i;
  logic           golden_i;
  logic           busy_o;
  logic           done_o;
  logic           pass_o;
  logic [NIN:0]   fail_cnt_o;
  logic [NIN-1:0] first_fail_o;
  logic           first_fail_vld_o;

  modport slave (
    input  start_i, skolem_i, golden_i,
    output vec_o, vec_vld_o, busy_o, done_o, pass_o,
           fail_cnt_o, first_fail_o, first_fail_vld_o
  );

  modport master (
    output start_i, skolem_i, golden_i,
    input  vec_o, vec_vld_o, busy_o, done_o, pass_o,
           fail_cnt_o, first_fail_o, first_fail_vld_o
  );
endinterface

// File: rtl/skolem_sweep_checker.sv
// rtl/skolem_sweep_checker.sv - exhaustive Skolem vs golden sweep checker; optional SKOLEM_STOP_ON_FAIL_EN
module skolem_sweep_checker #(
  parameter int NIN = 8,
  parameter int LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  skolem_sweep_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [2:0] DLAST = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

  state_t         state, state_d;
  logic [NIN-1:0] cnt;
  logic [2:0]     dcnt;
  logic           done_q;
  logic [NIN:0]   fail_cnt;
  logic [NIN-1:0] first_fail;
  logic           ff_vld;
  logic           al_vld;
  logic [NIN-1:0] al_vec;
  logic           active;
  logic           start_take;
  logic           mismatch;
  logic           flush;

  assign active     = (state == RUN) || (state == DRAIN);
  assign start_take = ((state == IDLE) || (state == DONE)) && bus.start_i;
  assign mismatch   = active && al_vld && (bus.skolem_i != bus.golden_i);
  // Leaving the sweep (normal end, early stop) discards whatever is still in flight
  assign flush      = (state_d == IDLE) || (state_d == DONE);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE, DONE: if (bus.start_i) state_d = RUN;
      RUN:        if (&cnt) state_d = (LAT > 0) ? DRAIN : DONE;
      DRAIN:      if (dcnt == DLAST) state_d = DONE;
      default:    state_d = IDLE;
    endcase
`ifdef SKOLEM_STOP_ON_FAIL_EN
    if (mismatch) state_d = DONE;
`endif
  end

  // Issue counter and drain counter
  always_ff @(posedge clk) begin
    if (!rst_n || start_take) begin
      cnt  <= '0;
      dcnt <= '0;
    end else if (state == RUN) begin
      cnt  <= cnt + 1'b1;
      dcnt <= '0;
    end else if (state == DRAIN) begin
      dcnt <= dcnt + 3'd1;
    end
  end

  // Response alignment: delay (valid, vector) by LAT cycles
  generate
    if (LAT == 0) begin : g_nopipe
      assign al_vld = (state == RUN);
      assign al_vec = cnt;
    end else begin : g_pipe
      logic           p_vld [LAT];
      logic [NIN-1:0] p_vec [LAT];

      // Shift the issued (valid, vector) pair down the pipe
      always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
          for (int k = 0; k < LAT; k++) begin
            p_vld[k] <= 1'b0;
            p_vec[k] <= '0;
          end
        end else begin
          p_vld[0] <= (state == RUN);
          p_vec[0] <= (state == RUN) ? cnt : '0;
          for (int k = 1; k < LAT; k++) begin
            p_vld[k] <= p_vld[k-1];
            p_vec[k] <= p_vec[k-1];
          end
        end
      end

      assign al_vld = p_vld[LAT-1];
      assign al_vec = p_vec[LAT-1];
    end
  endgenerate

  // Mismatch count and first-failure capture
  always_ff @(posedge clk) begin
    if (!rst_n || start_take) begin
      fail_cnt   <= '0;
      first_fail <= '0;
      ff_vld     <= 1'b0;
    end else if (mismatch) begin
      fail_cnt <= fail_cnt + 1'b1;
      if (!ff_vld) begin
        first_fail <= al_vec;
        ff_vld     <= 1'b1;
      end
    end
  end

  // done is raised one cycle after entering DONE so the final count has settled
  always_ff @(posedge clk) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= (state == DONE) && (state_d == DONE);
  end

  assign bus.vec_o            = (state == RUN) ? cnt : '0;
  assign bus.vec_vld_o        = (state == RUN);
  assign bus.busy_o           = active;
  assign bus.done_o           = done_q;
  assign bus.pass_o           = done_q && (fail_cnt == '0);
  assign bus.fail_cnt_o       = fail_cnt;
  assign bus.first_fail_o     = first_fail;
  assign bus.first_fail_vld_o = ff_vld;
endmodule

// File: tb/tb_skolem_sweep_checker.sv
// tb/tb_skolem_sweep_checker.sv - scoreboard bench for skolem_sweep_checker at LAT 0, 1 and 4
module tb_skolem_sweep_checker;
`ifdef SKOLEM_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  typedef struct {
    int cnt;
    int first;
    bit fvld;
    bit pass;
    int lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_a [3];
  logic [7:0] vec_a [3];
  logic       vld_a [3];
  logic       busy_a [3];
  logic       done_a [3];
  logic       pass_a [3];
  logic [8:0] cnt_a [3];
  logic [7:0] ff_a [3];
  logic       ffv_a [3];
  int         mode;
  logic [7:0] tgt8;
  int         checks = 0;
  int         errors = 0;
  exp_t       sbq[$];

  always #5 clk = ~clk;

  skolem_sweep_if #(.NIN(8)) bus [3] ();

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int L = (g == 0) ? 0 : (g == 1) ? 1 : 4;
      logic [7:0] hist [5];
      logic [7:0] dv;

      skolem_sweep_checker #(.NIN(8), .LAT(L)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus[g])
      );

      // Response model: golden is parity of the vector presented L cycles ago
      always @(posedge clk) begin
        hist[0] <= bus[g].vec_o;
        for (int k = 1; k < 5; k++) hist[k] <= hist[k-1];
      end

      assign dv = (L == 0) ? bus[g].vec_o : hist[(L == 0) ? 0 : L - 1];
      assign bus[g].golden_i = ^dv;
      assign bus[g].skolem_i = (^dv) ^ ((mode == 2) || ((mode == 1) && (dv == tgt8)));
      assign bus[g].start_i  = start_a[g];

      assign vec_a[g]  = bus[g].vec_o;
      assign vld_a[g]  = bus[g].vec_vld_o;
      assign busy_a[g] = bus[g].busy_o;
      assign done_a[g] = bus[g].done_o;
      assign pass_a[g] = bus[g].pass_o;
      assign cnt_a[g]  = bus[g].fail_cnt_o;
      assign ff_a[g]   = bus[g].first_fail_o;
      assign ffv_a[g]  = bus[g].first_fail_vld_o;
    end
  endgenerate

  function automatic exp_t model(int m, int tgt, int lat);
    exp_t e;
    e.cnt   = (m == 0) ? 0 : (m == 1) ? 1 : (STOP ? 1 : 256);
    e.first = (m == 1) ? tgt : 0;
    e.fvld  = (m != 0);
    e.pass  = (m == 0);
    e.lat   = (STOP && m == 2) ? lat + 2 : 256 + lat + 1;
    return e;
  endfunction

  task automatic pulse_start(int j);
    start_a[j] = 1'b1;
    @(posedge clk); #1;
    start_a[j] = 1'b0;
  endtask

  // Pops the expected result and compares it when done_o rises
  task automatic score(int j, int poke, string name);
    exp_t e;
    int   cyc;
    bit   seen;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty: got 0 entries, need 1", name);
      return;
    end
    e = sbq.pop_front();
    cyc = 0;
    seen = 1'b0;
    while (cyc < 600 && !seen) begin
      start_a[j] = (poke >= 0) && vld_a[j] && (vec_a[j] == poke[7:0]);
      @(posedge clk); #1;
      cyc++;
      if (done_a[j]) seen = 1'b1;
    end
    start_a[j] = 1'b0;
    if (!seen || cyc != e.lat) begin
      errors++;
      $display("FAIL %s done latency: got %0d (seen=%0d), need %0d", name, cyc, seen, e.lat);
    end
    checks++;
    if (cnt_a[j] !== 9'(e.cnt)) begin
      errors++;
      $display("FAIL %s fail_cnt: got %0d, need %0d", name, cnt_a[j], e.cnt);
    end
    checks++;
    if (ffv_a[j] !== e.fvld) begin
      errors++;
      $display("FAIL %s first_fail_vld: got %0b, need %0b", name, ffv_a[j], e.fvld);
    end
    checks++;
    if (pass_a[j] !== e.pass) begin
      errors++;
      $display("FAIL %s pass: got %0b, need %0b", name, pass_a[j], e.pass);
    end
    if (e.fvld) begin
      checks++;
      if (ff_a[j] !== 8'(e.first)) begin
        errors++;
        $display("FAIL %s first_fail: got %h, need %h", name, ff_a[j], 8'(e.first));
      end
    end
  endtask

  task automatic check_zero(int j, string name);
    checks++;
    if ({vec_a[j], vld_a[j], busy_a[j], done_a[j], pass_a[j], cnt_a[j], ff_a[j], ffv_a[j]} !== '0) begin
      errors++;
      $display("FAIL %s outputs: got vec=%h vld=%b busy=%b done=%b pass=%b cnt=%0d ff=%h ffv=%b, need all 0",
               name, vec_a[j], vld_a[j], busy_a[j], done_a[j], pass_a[j], cnt_a[j], ff_a[j], ffv_a[j]);
    end
  endtask

  task automatic run_sweep(int j, int m, int tgt, int lat, string name);
    mode = m;
    tgt8 = 8'(tgt);
    sbq.push_back(model(m, tgt, lat));
    pulse_start(j);
    score(j, -1, name);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int j = 0; j < 3; j++) check_zero(j, "reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_clean();
    run_sweep(1, 0, 0, 1, "clean");
  endtask

  task automatic test_single_mismatch();
    run_sweep(1, 1, 8'hA5, 1, "single_a5");
  endtask

  task automatic test_all_inverted();
    run_sweep(1, 2, 0, 1, "all_inv_lat1");
    run_sweep(0, 2, 0, 0, "all_inv_lat0");
  endtask

  task automatic test_start_ignored();
    mode = 1;
    tgt8 = 8'h10;
    sbq.push_back(model(1, 8'h10, 1));
    pulse_start(1);
    score(1, 8'h40, "start_in_run");
  endtask

  task automatic test_restart_from_done();
    mode = 0;
    sbq.push_back(model(0, 0, 1));
    pulse_start(1);
    checks++;
    if (done_a[1] !== 1'b0 || vld_a[1] !== 1'b1 || vec_a[1] !== 8'h00) begin
      errors++;
      $display("FAIL restart entry: got done=%b vld=%b vec=%h, need done=0 vld=1 vec=00", done_a[1], vld_a[1], vec_a[1]);
    end
    checks++;
    if (cnt_a[1] !== 9'd0 || ffv_a[1] !== 1'b0) begin
      errors++;
      $display("FAIL restart clear: got cnt=%0d ffv=%b, need cnt=0 ffv=0", cnt_a[1], ffv_a[1]);
    end
    score(1, -1, "restart");
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    bit seen;
    mode = 2;
    pulse_start(1);
    cyc = 0;
    while (cyc < 300 && vec_a[1] !== 8'd100) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (vec_a[1] !== 8'd100 || busy_a[1] !== 1'b1) begin
      errors++;
      $display("FAIL midreset reach: got vec=%0d busy=%b, need vec=100 busy=1", vec_a[1], busy_a[1]);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_zero(1, "midreset");
    seen = 1'b0;
    repeat (300) begin
      @(posedge clk); #1;
      if (done_a[1] || busy_a[1] || vld_a[1]) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL midreset idle: got activity after reset, need none");
    end
    mode = 0;
  endtask

  task automatic test_lat0_lat4();
    run_sweep(0, 1, 8'hFF, 0, "lat0_ff");
    run_sweep(2, 1, 8'hFF, 4, "lat4_ff");
    run_sweep(2, 0, 0, 4, "lat4_clean");
  endtask

  initial begin
    for (int j = 0; j < 3; j++) start_a[j] = 1'b0;
    mode = 0;
    tgt8 = 8'h00;
    rst_n = 1'b0;
    test_reset();
    test_clean();
    test_single_mismatch();
    test_all_inverted();
    test_start_ignored();
    test_restart_from_done();
    test_reset_mid_run();
    test_lat0_lat4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/skolem_sweep_checker.md
SKOLEM_SWEEP_CHECKER -- requirements
Module: skolem_sweep_checker

Interface
REQ-001 Parameter NIN, default 8: number of Skolem-function inputs swept; legal range 2..16.
REQ-002 Parameter LAT, default 1: response latency in clk cycles from vec_o to skolem_i/golden_i; legal range 0..4.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 start_i  input  1  sweep request; sampled high in IDLE or DONE.
REQ-006 vec_o  output  NIN  input assignment driven to the function under test and to the golden model; bit k drives input i<k>.
REQ-007 vec_vld_o  output  1  vec_o carries a live assignment this cycle.
REQ-008 skolem_i  input  1  output of the Skolem function under test.
REQ-009 golden_i  input  1  output of the golden (spec-derived) function.
REQ-010 busy_o  output  1  high in RUN and DRAIN.
REQ-011 done_o  output  1  high in DONE; held until the next start or reset.
REQ-012 pass_o  output  1  valid while done_o is high; 1 iff fail_cnt_o == 0.
REQ-013 fail_cnt_o  output  NIN+1  number of mismatching assignments.
REQ-014 first_fail_o  output  NIN  lowest-numbered mismatching assignment.
REQ-015 first_fail_vld_o  output  1  first_fail_o holds a captured value.

Function
REQ-016 FSM states SHALL be IDLE, RUN, DRAIN and DONE.
REQ-017 IDLE or DONE with start_i=1: next state RUN; fail_cnt_o, first_fail_o, first_fail_vld_o and the issue counter cleared to 0 in the same edge.
REQ-018 start_i SHALL be ignored in RUN and DRAIN.
REQ-019 RUN: vec_o = issue counter, vec_vld_o = 1; the counter increments by 1 per cycle, so 0 .. 2^NIN-1 are presented in consecutive cycles with no gaps.
REQ-020 After 2^NIN-1 is presented: next state DRAIN if LAT>0, else DONE; the counter wraps to 0 and the wrapped value is not reissued.
REQ-021 DRAIN: lasts exactly LAT cycles with vec_vld_o = 0, then DONE.
REQ-022 A LAT-deep pipeline of (valid, vector) SHALL align each response with the vector issued LAT cycles earlier; with LAT=0 the comparison is same-cycle.
REQ-023 An aligned valid response with skolem_i != golden_i increments fail_cnt_o by 1.
REQ-024 On the first such mismatch of a sweep, first_fail_o captures the aligned vector and first_fail_vld_o goes to 1; later mismatches do not overwrite the capture.
REQ-025 fail_cnt_o SHALL not saturate; its width holds the maximum count 2^NIN.
REQ-026 done_o SHALL rise exactly 2^NIN+LAT+1 cycles after the edge that samples start_i.
REQ-027 Outside RUN, vec_o SHALL hold 0.

Reset
REQ-028 rst_n=0 at a clock edge: state IDLE, the pipeline is flushed, and vec_o, vec_vld_o, busy_o, done_o, pass_o, fail_cnt_o, first_fail_o and first_fail_vld_o all become 0.
REQ-029 Reset in any state, including mid-RUN or mid-DRAIN, SHALL abandon the sweep; in-flight responses are discarded.

Configuration
REQ-030 With macro SKOLEM_STOP_ON_FAIL_EN defined, the first counted mismatch SHALL force next state DONE: vec_vld_o goes low on the next cycle, remaining in-flight responses are discarded, fail_cnt_o = 1 and pass_o = 0.
REQ-031 Without SKOLEM_STOP_ON_FAIL_EN, every assignment SHALL be swept and counted regardless of mismatches.

Verification (NIN=8, LAT=1 unless noted)
REQ-032 golden_i tied to skolem_i, start pulse -> done_o high 258 cycles after start; pass_o=1, fail_cnt_o=0, first_fail_vld_o=0.
REQ-033 golden_i differs only for aligned vector 8'hA5 -> fail_cnt_o=1, first_fail_o=8'hA5, first_fail_vld_o=1, pass_o=0.
REQ-034 skolem_i = ~golden_i, macro undefined -> fail_cnt_o=256, first_fail_o=8'h00; with macro defined -> DONE two cycles after vec 8'h00 issued, fail_cnt_o=1.
REQ-035 start_i pulsed at vec 8'h40 in RUN -> no effect, sweep completes normally; start_i in DONE -> counters clear and a new sweep begins at vec 8'h00.
REQ-036 rst_n low for one edge while vec_o=8'd100 -> all outputs 0 and state IDLE on that edge; no done_o follows without a new start.
REQ-037 LAT=0 and LAT=4, with a mismatch at vector 8'hFF -> first_fail_o=8'hFF and done_o at 257 and 261 cycles after start respectively.
